// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with one register stage per shift-amount bit,
// global-stall valid/ready flow control and a sideband tag carried alongside the data.
module shift_pipe #(
    parameter int unsigned  WIDTH = 32,
    parameter int unsigned  TAGW  = 5,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             busy
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic [WIDTH-1:0] r_data [SHW];
    logic [SHW-1:0]   r_amt  [SHW];
    logic [1:0]       r_op   [SHW];
    logic [TAGW-1:0]  r_tag  [SHW];
    logic             r_sign [SHW];
    logic [SHW-1:0]   r_valid;

    logic [WIDTH-1:0] w_src_data [SHW];
    logic [SHW-1:0]   w_src_amt  [SHW];
    logic [1:0]       w_src_op   [SHW];
    logic [TAGW-1:0]  w_src_tag  [SHW];
    logic             w_src_sign [SHW];
    logic [WIDTH-1:0] w_step     [SHW];
    logic             w_advance;

    // One conditional shift by sh; the SRA fill comes from the sign captured at entry.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             sign,
        input logic             en,
        input int unsigned      sh
    );
        logic [WIDTH-1:0] fill;
        fill   = sign ? ~({WIDTH{1'b1}} >> sh) : '0;
        f_step = d;
        if (en) begin
            case (op)
                OP_SLL:  f_step = d << sh;
                OP_SRL:  f_step = d >> sh;
                OP_SRA:  f_step = (d >> sh) | fill;
                default: f_step = (d << sh) | (d >> (WIDTH - sh));
            endcase
        end
    endfunction

    // Stage k consumes the MSB of its amount field; the field is shifted left as it moves on.
    always_comb begin : src_sel
        w_src_data[0] = in_data;
        w_src_amt[0]  = in_amt;
        w_src_op[0]   = in_op;
        w_src_tag[0]  = in_tag;
        w_src_sign[0] = in_data[WIDTH-1];
        for (int k = 1; k < SHW; k++) begin
            w_src_data[k] = r_data[k-1];
            w_src_amt[k]  = r_amt[k-1];
            w_src_op[k]   = r_op[k-1];
            w_src_tag[k]  = r_tag[k-1];
            w_src_sign[k] = r_sign[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            w_step[k] = f_step(w_src_data[k], w_src_op[k], w_src_sign[k],
                               w_src_amt[k][SHW-1], WIDTH >> (k + 1));
        end
    end

    assign w_advance = out_ready | ~r_valid[SHW-1];

    always_ff @(posedge clock or posedge reset) begin : stage_regs
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < SHW; k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_op[k]   <= '0;
                r_tag[k]  <= '0;
                r_sign[k] <= 1'b0;
            end
        end else if (w_advance) begin
            r_valid <= {r_valid[SHW-2:0], in_valid};
            for (int k = 0; k < SHW; k++) begin
                r_data[k] <= w_step[k];
                r_amt[k]  <= w_src_amt[k] << 1;
                r_op[k]   <= w_src_op[k];
                r_tag[k]  <= w_src_tag[k];
                r_sign[k] <= w_src_sign[k];
            end
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_valid[SHW-1];
    assign out_data  = r_data[SHW-1];
    assign out_tag   = r_tag[SHW-1];
    assign busy      = |r_valid;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed vectors with literal results plus a queue-based reference model
// checked every cycle, for a 32-bit/5-bit-tag instance and an 8-bit/1-bit-tag instance.
module tb_shift_pipe;

    logic        clock;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_op;
    logic [4:0]  in_tag, out_tag;

    logic        in8_valid, in8_ready, out8_valid, out8_ready, busy8;
    logic [7:0]  in8_data, out8_data;
    logic [2:0]  in8_amt;
    logic [1:0]  in8_op;
    logic [0:0]  in8_tag, out8_tag;

    int checks = 0;
    int errors = 0;
    int pops32 = 0;
    int pops8  = 0;

    typedef struct { logic [31:0] d; logic [4:0] t; } e32_t;
    typedef struct { logic [7:0]  d; logic [0:0] t; } e8_t;
    e32_t q32[$];
    e8_t  q8[$];

    shift_pipe #(.WIDTH(32), .TAGW(5)) u_dut32 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    shift_pipe #(.WIDTH(8), .TAGW(1)) u_dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data), .in_amt(in8_amt),
        .in_op(in8_op), .in_tag(in8_tag),
        .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data), .out_tag(out8_tag),
        .busy(busy8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result from the mode definitions, computed in a 64-bit field masked to w bits.
    function automatic logic [31:0] model(input logic [31:0] d, input int a, input int op, input int w);
        logic [63:0] mask, x, r;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        case (op)
            0:       r = (x << a) & mask;
            1:       r = x >> a;
            2:       r = (x >> a) | (x[w-1] ? (mask & ~(mask >> a)) : 64'd0);
            default: r = ((x << a) | (x >> (w - a))) & mask;
        endcase
        return r[31:0];
    endfunction

    // Scoreboard for the 32-bit instance: every cycle, away from the rising edge.
    always @(negedge clock) begin
        if (reset) begin
            q32.delete();
        end else begin
            chk("busy32", 64'(busy), 64'(q32.size() != 0));
            chk("in_ready32", 64'(in_ready), 64'(out_ready || !out_valid));
            if (out_valid) begin
                if (q32.size() == 0) chk("spurious_out32", 64'(out_valid), 64'd0);
                else begin
                    chk("out_data32", 64'(out_data), 64'(q32[0].d));
                    chk("out_tag32", 64'(out_tag), 64'(q32[0].t));
                    if (out_ready) begin
                        void'(q32.pop_front());
                        pops32++;
                    end
                end
            end
            if (in_valid && in_ready)
                q32.push_back('{d: model(in_data, int'(in_amt), int'(in_op), 32), t: in_tag});
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            q8.delete();
        end else begin
            chk("busy8", 64'(busy8), 64'(q8.size() != 0));
            chk("in_ready8", 64'(in8_ready), 64'(out8_ready || !out8_valid));
            if (out8_valid) begin
                if (q8.size() == 0) chk("spurious_out8", 64'(out8_valid), 64'd0);
                else begin
                    chk("out_data8", 64'(out8_data), 64'(q8[0].d));
                    chk("out_tag8", 64'(out8_tag), 64'(q8[0].t));
                    if (out8_ready) begin
                        void'(q8.pop_front());
                        pops8++;
                    end
                end
            end
            if (in8_valid && in8_ready) begin
                logic [31:0] m;
                m = model({24'd0, in8_data}, int'(in8_amt), int'(in8_op), 8);
                q8.push_back('{d: m[7:0], t: in8_tag});
            end
        end
    end

    // Single op on an idle pipe; lat counts rising edges from the accept edge to out_valid.
    task automatic op32(input logic [31:0] d, input int a, input logic [1:0] op, input logic [4:0] t,
                        input logic [31:0] exp_d, input string nm);
        int lat;
        in_valid = 1'b1; in_data = d; in_amt = 5'(a); in_op = op; in_tag = t;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd5);
        chk({nm, "_data"}, 64'(out_data), 64'(exp_d));
        chk({nm, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clock); #1;
    endtask

    task automatic op8(input logic [7:0] d, input int a, input logic [1:0] op, input logic [0:0] t,
                       input logic [7:0] exp_d, input string nm);
        int lat;
        in8_valid = 1'b1; in8_data = d; in8_amt = 3'(a); in8_op = op; in8_tag = t;
        @(posedge clock); #1;
        in8_valid = 1'b0;
        lat = 1;
        while (!out8_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({nm, "_lat"}, 64'(lat), 64'd3);
        chk({nm, "_data"}, 64'(out8_data), 64'(exp_d));
        chk({nm, "_tag"}, 64'(out8_tag), 64'(t));
        @(posedge clock); #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tags[$];
        int sent, guard, p0, nspur;

        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_data = '0; in8_amt = '0; in8_op = '0; in8_tag = '0; out8_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst8_out_valid", 64'(out8_valid), 64'd0);
        chk("rst8_out_data", 64'(out8_data), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        op32(32'h0000_0001, 31, 2'd0, 5'd3,  32'h8000_0000, "sll31");
        op32(32'h8000_0000, 4,  2'd2, 5'd4,  32'hF800_0000, "sra4_neg");
        op32(32'h8000_0000, 4,  2'd1, 5'd5,  32'h0800_0000, "srl4");
        op32(32'h7FFF_FFF0, 4,  2'd2, 5'd6,  32'h07FF_FFFF, "sra4_pos");
        op32(32'h8000_0001, 1,  2'd3, 5'd7,  32'h0000_0003, "rol1");
        op32(32'h1234_5678, 16, 2'd3, 5'd8,  32'h5678_1234, "rol16");
        op32(32'hA5C3_0F81, 0,  2'd0, 5'd9,  32'hA5C3_0F81, "sll0");
        op32(32'hA5C3_0F81, 0,  2'd1, 5'd10, 32'hA5C3_0F81, "srl0");
        op32(32'hA5C3_0F81, 0,  2'd2, 5'd11, 32'hA5C3_0F81, "sra0");
        op32(32'hA5C3_0F81, 0,  2'd3, 5'd31, 32'hA5C3_0F81, "rol0");

        // Six back-to-back ops, consumer stalls in cycles 7..9.
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = (cyc < 6);
            in_data   = 32'(cyc * 32'h1111_0003 + 1);
            in_amt    = 5'(cyc * 5);
            in_op     = 2'(cyc % 4);
            in_tag    = 5'(cyc);
            out_ready = !(cyc >= 7 && cyc <= 9);
            @(negedge clock);
            if (cyc >= 7 && cyc <= 9) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) tags.push_back(int'(out_tag));
            @(posedge clock); #1;
        end
        chk("bp_count", 64'(tags.size()), 64'd6);
        foreach (tags[i]) chk("bp_order", 64'(tags[i]), 64'(i));

        // Random valid/ready traffic against the scoreboard.
        p0 = pops32; sent = 0; guard = 0;
        while (sent < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_amt    = 5'($urandom_range(0, 31));
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            @(posedge clock); #1;
            guard++;
        end
        in_valid = 1'b0; out_ready = 1'b1; guard = 0;
        while (busy && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        chk("rand_drained", 64'(busy), 64'd0);
        chk("rand_delivered", 64'(pops32 - p0), 64'(sent));

        // Three ops in flight, asynchronous reset between edges once the first reaches the output.
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 3); in_data = 32'h100 + 32'(c); in_amt = 5'(c + 1);
            in_op = 2'(c); in_tag = 5'(c + 10);
            @(posedge clock); #1;
        end
        #2;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_out_valid", 64'(out_valid), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_out_data", 64'(out_data), 64'd0);
        @(posedge clock); #3;
        reset = 1'b0;
        nspur = 0;
        repeat (12) begin
            @(posedge clock); #1;
            if (out_valid) nspur++;
        end
        chk("post_rst_no_output", 64'(nspur), 64'd0);
        op32(32'h0000_00F0, 4, 2'd1, 5'd21, 32'h0000_000F, "after_rst");

        op8(8'h01, 7, 2'd0, 1'b1, 8'h80, "w8_sll7");
        op8(8'h80, 7, 2'd2, 1'b0, 8'hFF, "w8_sra7");
        op8(8'h81, 4, 2'd3, 1'b1, 8'h18, "w8_rol4");
        op8(8'h80, 7, 2'd1, 1'b0, 8'h01, "w8_srl7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
